// File: rtl/bitop_pipe_flopped.sv
// rtl/bitop_pipe_flopped.sv - elastic valid/ready pipelined bitwise-op unit with square-fold pre-stage
module bitop_pipe_flopped #(
    parameter int BITWIDTH            = 16,
    parameter int NUM_PIPELINE_STAGES = 1,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BITWIDTH-1:0]  in_a,
    input  logic [BITWIDTH-1:0]  in_b,
    input  logic [1:0]           in_op,
    input  logic                 in_fold,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BITWIDTH-1:0]  out_data,
    output logic [1:0]           out_op,
    output logic [CNT_WIDTH-1:0] out_count
);

    localparam int N = NUM_PIPELINE_STAGES;
    localparam int W = BITWIDTH;

    logic [N-1:0]   r_in_valid;
    logic [W-1:0]   r_in_a    [N];
    logic [W-1:0]   r_in_b    [N];
    logic [1:0]     r_in_op   [N];
    logic           r_in_fold [N];

    logic           r_sq_valid;
    logic [2*W-1:0] r_sq_a;
    logic [2*W-1:0] r_sq_b;
    logic [1:0]     r_sq_op;

    logic           r_fold_valid;
    logic [W-1:0]   r_fold_a;
    logic [W-1:0]   r_fold_b;
    logic [1:0]     r_fold_op;

    logic           r_out_valid;
    logic [W-1:0]   r_out_data;
    logic [1:0]     r_out_op;
    logic [CNT_WIDTH-1:0] r_count;

    logic           w_out_rdy;
    logic           w_fold_rdy;
    logic           w_sq_rdy;
    logic [N-1:0]   w_in_rdy;
    logic           w_all_full;
    logic [2*W-1:0] w_sq_a;
    logic [2*W-1:0] w_sq_b;
    logic [W-1:0]   w_op_res;

    assign w_out_rdy  = !r_out_valid || out_ready;
    assign w_fold_rdy = !r_fold_valid || w_out_rdy;
    assign w_sq_rdy   = !r_sq_valid || w_fold_rdy;

    // An input stage can take data if the square stage drains or any stage
    // from it onward has a bubble; written without a self-referencing chain.
    always_comb begin
        w_in_rdy   = '0;
        w_all_full = 1'b1;
        for (int k = N - 1; k >= 0; k--) begin
            w_all_full  = w_all_full & r_in_valid[k];
            w_in_rdy[k] = w_sq_rdy || !w_all_full;
        end
    end

    assign in_ready = w_in_rdy[0];

    always_comb begin
        w_sq_a = {{W{1'b0}}, r_in_a[N-1]};
        w_sq_b = {{W{1'b0}}, r_in_b[N-1]};
        if (r_in_fold[N-1]) begin
            w_sq_a = {{W{1'b0}}, r_in_a[N-1]} * {{W{1'b0}}, r_in_a[N-1]};
            w_sq_b = {{W{1'b0}}, r_in_b[N-1]} * {{W{1'b0}}, r_in_b[N-1]};
        end
    end

    always_comb begin
        w_op_res = r_fold_a & r_fold_b;
        case (r_fold_op)
            2'd0:    w_op_res = r_fold_a & r_fold_b;
            2'd1:    w_op_res = r_fold_a | r_fold_b;
            2'd2:    w_op_res = r_fold_a ^ r_fold_b;
            default: w_op_res = ~(r_fold_a ^ r_fold_b);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_valid   <= '0;
            r_sq_valid   <= 1'b0;
            r_fold_valid <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_op     <= 2'd0;
            r_count      <= '0;
        end else begin
            if (w_in_rdy[0]) r_in_valid[0] <= in_valid;
            for (int k = 1; k < N; k++) begin
                if (w_in_rdy[k]) r_in_valid[k] <= r_in_valid[k-1];
            end
            if (w_sq_rdy)   r_sq_valid   <= r_in_valid[N-1];
            if (w_fold_rdy) r_fold_valid <= r_sq_valid;
            if (w_out_rdy)  r_out_valid  <= r_fold_valid;
            if (w_out_rdy && r_fold_valid) begin
                r_out_data <= w_op_res;
                r_out_op   <= r_fold_op;
            end
            if (r_out_valid && out_ready) r_count <= r_count + 1'b1;
        end
    end

    // Payload registers load only alongside a valid bit, so X on idle inputs never moves.
    always_ff @(posedge clk) begin
        if (w_in_rdy[0] && in_valid) begin
            r_in_a[0]    <= in_a;
            r_in_b[0]    <= in_b;
            r_in_op[0]   <= in_op;
            r_in_fold[0] <= in_fold;
        end
        for (int k = 1; k < N; k++) begin
            if (w_in_rdy[k] && r_in_valid[k-1]) begin
                r_in_a[k]    <= r_in_a[k-1];
                r_in_b[k]    <= r_in_b[k-1];
                r_in_op[k]   <= r_in_op[k-1];
                r_in_fold[k] <= r_in_fold[k-1];
            end
        end
        if (w_sq_rdy && r_in_valid[N-1]) begin
            r_sq_a  <= w_sq_a;
            r_sq_b  <= w_sq_b;
            r_sq_op <= r_in_op[N-1];
        end
        if (w_fold_rdy && r_sq_valid) begin
            r_fold_a  <= r_sq_a[W-1:0] ^ r_sq_a[2*W-1:W];
            r_fold_b  <= r_sq_b[W-1:0] ^ r_sq_b[2*W-1:W];
            r_fold_op <= r_sq_op;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_op    = r_out_op;
    assign out_count = r_count;

endmodule

// File: tb/tb_bitop_pipe_flopped.sv
// tb/tb_bitop_pipe_flopped.sv - randomized self-checking bench for bitop_pipe_flopped
module tb_bitop_pipe_flopped;

    localparam int W   = 16;
    localparam int NPS = 2;
    localparam int LAT = NPS + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [1:0]    in_op = 2'd0;
    logic          in_fold = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [1:0]    out_op;
    logic [15:0]   out_count;
    logic          c4_in_ready;
    logic          c4_out_valid;
    logic [W-1:0]  c4_out_data;
    logic [1:0]    c4_out_op;
    logic [3:0]    c4_out_count;

    always #5 clk = ~clk;

    bitop_pipe_flopped #(.BITWIDTH(W), .NUM_PIPELINE_STAGES(NPS), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_fold(in_fold),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_op(out_op), .out_count(out_count)
    );

    bitop_pipe_flopped #(.BITWIDTH(W), .NUM_PIPELINE_STAGES(NPS), .CNT_WIDTH(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c4_in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_fold(in_fold),
        .out_valid(c4_out_valid), .out_ready(out_ready), .out_data(c4_out_data),
        .out_op(c4_out_op), .out_count(c4_out_count)
    );

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    int unsigned   model_cnt = 0;
    int unsigned   cyc = 0;
    logic [17:0]   exp_q[$];
    logic [W-1:0]  got_data[$];
    int unsigned   got_cyc[$];
    logic          hold = 1'b0;
    logic [W-1:0]  hold_data;
    logic [1:0]    hold_op;

    function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [1:0] op, input logic fold);
        int unsigned ua, ub, pa, pb;
        logic [W-1:0] x, y;
        ua = a;
        ub = b;
        x = a;
        y = b;
        if (fold) begin
            pa = ua * ua;
            pb = ub * ub;
            x = pa[15:0] ^ pa[31:16];
            y = pb[15:0] ^ pb[31:16];
        end
        case (op)
            2'd0:    return x & y;
            2'd1:    return x | y;
            2'd2:    return x ^ y;
            default: return ~(x ^ y);
        endcase
    endfunction

    task automatic step();
        logic [17:0] e;
        #1;
        cyc++;
        checks++;
        if (out_count !== model_cnt[15:0]) begin
            errors++;
            $display("FAIL out_count: got %0d expected %0d", out_count, model_cnt[15:0]);
        end
        checks++;
        if (c4_out_count !== model_cnt[3:0]) begin
            errors++;
            $display("FAIL c4_out_count: got %0d expected %0d", c4_out_count, model_cnt[3:0]);
        end
        if (hold) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== hold_data || out_op !== hold_op) begin
                errors++;
                $display("FAIL stall_stable: got v=%b d=%h op=%0d expected v=1 d=%h op=%0d",
                         out_valid, out_data, out_op, hold_data, hold_op);
            end
        end
        if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_result: got d=%h op=%0d expected no result", out_data, out_op);
            end else begin
                e = exp_q.pop_front();
                if ({out_op, out_data} !== e) begin
                    errors++;
                    $display("FAIL result: got op=%0d d=%h expected op=%0d d=%h",
                             out_op, out_data, e[17:16], e[15:0]);
                end
                got_data.push_back(out_data);
                got_cyc.push_back(cyc);
            end
            model_cnt++;
        end
        if (in_valid && in_ready)
            exp_q.push_back({in_op, ref_result(in_a, in_b, in_op, in_fold)});
        hold      = out_valid && !out_ready;
        hold_data = out_data;
        hold_op   = out_op;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (4) step();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        hold = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_count !== 16'd0 || out_data !== '0 || out_op !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b cnt=%0d d=%h op=%0d expected all 0",
                     out_valid, out_count, out_data, out_op);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        do_reset();
    endtask

    task automatic test_basic();
        int lat;
        in_a = 16'd3; in_b = 16'd5; in_op = 2'd2; in_fold = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            #1;
            if (out_valid) break;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (out_data !== 16'h0010 || out_op !== 2'd2) begin
            errors++;
            $display("FAIL basic_xor: got d=%h op=%0d expected d=0010 op=2", out_data, out_op);
        end
        step();
        #1;
        checks++;
        if (out_count !== 16'd1) begin
            errors++;
            $display("FAIL basic_count: got %0d expected 1", out_count);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] want [4] = '{16'h0001, 16'hFE01, 16'hFE00, 16'h01FF};
        got_data.delete();
        got_cyc.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = 16'h0100; in_b = 16'h00FF; in_op = 2'(i); in_fold = 1'b1;
            in_valid = 1'b1;
            step();
        end
        drain();
        checks++;
        if (got_data.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 4", got_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_data[i] !== want[i] || got_cyc[i] != got_cyc[0] + i) begin
                    errors++;
                    $display("FAIL b2b_%0d: got d=%h cyc+%0d expected d=%h cyc+%0d",
                             i, got_data[i], got_cyc[i] - got_cyc[0], want[i], i);
                end
            end
        end
    endtask

    task automatic test_raw();
        got_data.delete();
        out_ready = 1'b1;
        in_a = 16'hF0F0; in_b = 16'hFF00; in_fold = 1'b0; in_valid = 1'b1;
        in_op = 2'd0;
        step();
        in_op = 2'd3;
        step();
        drain();
        checks++;
        if (got_data.size() != 2 || got_data[0] !== 16'hF000 || got_data[1] !== 16'hF00F) begin
            errors++;
            $display("FAIL raw_ops: got n=%0d d0=%h d1=%h expected n=2 F000 F00F",
                     got_data.size(), got_data.size() > 0 ? got_data[0] : 16'h0,
                     got_data.size() > 1 ? got_data[1] : 16'h0);
        end
    endtask

    task automatic test_backpressure();
        int acc;
        got_data.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_a = W'($urandom); in_b = W'($urandom);
            in_op = 2'($urandom); in_fold = 1'($urandom);
            step();
        end
        acc = exp_q.size();
        checks++;
        if (acc != LAT) begin
            errors++;
            $display("FAIL bp_accepts: got %0d expected %0d", acc, LAT);
        end
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready: got %b expected 0", in_ready);
        end
        @(negedge clk);
        drain();
        checks++;
        if (got_data.size() != acc) begin
            errors++;
            $display("FAIL bp_delivered: got %0d expected %0d", got_data.size(), acc);
        end
    endtask

    task automatic test_random();
        int unsigned acc, budget;
        acc = 0;
        budget = 0;
        got_data.delete();
        while (acc < 1000 && budget < 20000) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            if (in_valid) begin
                in_a = W'($urandom); in_b = W'($urandom);
                in_op = 2'($urandom); in_fold = 1'($urandom);
            end else begin
                in_a = 'x; in_b = 'x;
            end
            #1;
            if (in_valid && in_ready) acc++;
            #0;
            step();
            budget++;
        end
        checks++;
        if (acc < 1000) begin
            errors++;
            $display("FAIL random_budget: got %0d accepts expected 1000", acc);
        end
        drain();
        checks++;
        if (got_data.size() != acc) begin
            errors++;
            $display("FAIL random_delivered: got %0d expected %0d", got_data.size(), acc);
        end
    endtask

    task automatic test_reset_midflight();
        got_data.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = W'($urandom); in_b = W'($urandom);
            in_op = 2'($urandom); in_fold = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_count !== 16'd0 || c4_out_count !== 4'd0) begin
            errors++;
            $display("FAIL midflight_reset: got v=%b cnt=%0d c4=%0d expected 0 0 0",
                     out_valid, out_count, c4_out_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        hold = 1'b0;
        in_a = 16'h1234; in_b = 16'h00F0; in_op = 2'd1; in_fold = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        drain();
        repeat (6) step();
        checks++;
        if (got_data.size() != 1 || got_data[0] !== 16'h12F4) begin
            errors++;
            $display("FAIL post_reset_single: got n=%0d d=%h expected n=1 d=12F4",
                     got_data.size(), got_data.size() > 0 ? got_data[0] : 16'h0);
        end
    endtask

    task automatic test_count_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_a = W'($urandom); in_b = W'($urandom);
            in_op = 2'($urandom); in_fold = 1'($urandom);
            step();
        end
        drain();
        #1;
        checks++;
        if (c4_out_count !== 4'd1 || out_count !== 16'd17) begin
            errors++;
            $display("FAIL count_wrap: got c4=%0d cnt=%0d expected c4=1 cnt=17",
                     c4_out_count, out_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_raw();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_count_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bitop_pipe_flopped.md
Name: bitop_pipe_flopped

Overview:
- Parametrised successor to the fixed 16-bit flopped XOR test block.
- Elastic, valid/ready pipelined bitwise-operation unit with selectable operation and an optional square-fold pre-stage.
- Carries a per-transaction mode through the pipe, supports backpressure at every stage, and counts delivered results.
- Sits between the input harness and the output register ring of the synthesis test designs, so that timing-closure runs can sweep width, depth and operation.

Parameters:
- BITWIDTH, 16, operand and result width in bits; legal range >= 2.
- NUM_PIPELINE_STAGES, 1, number of input register stages before the pre-stage; legal range >= 1.
- CNT_WIDTH, 16, width of the delivered-result counter.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  pipe accepts the input this cycle.
- in_a  input  BITWIDTH  operand A.
- in_b  input  BITWIDTH  operand B.
- in_op  input  2  operation: 0=AND, 1=OR, 2=XOR, 3=XNOR.
- in_fold  input  1  1=square-fold pre-stage applied, 0=operands passed raw.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_data  output  BITWIDTH  result.
- out_op  output  2  in_op that travelled with this result.
- out_count  output  CNT_WIDTH  number of results delivered since reset.

Behaviour:
- Reset: async assert clears every stage valid bit, out_data, out_op and out_count to 0; in_ready=1 after reset (pipe empty). Data registers other than out_data need not reset.
- Stages, in order:
  - S_IN[0..NUM_PIPELINE_STAGES-1]: register {a, b, op, fold}.
  - S_SQ: register 2*BITWIDTH products. When fold=1: a*a and b*b, unsigned. When fold=0: zero-extended a and b.
  - S_FOLD: register product[BITWIDTH-1:0] ^ product[2*BITWIDTH-1:BITWIDTH] for each operand. fold=0 therefore yields raw operands.
  - S_OUT: register op(a', b') into out_data, op into out_op.
- Each stage holds a valid bit. Stage k loads from k-1 when (!valid_k || advance_k+1); advance of S_OUT = out_valid && out_ready.
- in_ready = !valid_S_IN[0] || S_IN[0] loads onward (combinational from downstream; no combinational path from in_valid to in_ready).
- Transfer occurs only on valid && ready; a stage that neither loads nor drains holds data and valid unchanged.
- Latency: NUM_PIPELINE_STAGES+3 cycles from input transfer to out_valid with no stalls. Throughput 1/cycle with out_ready held high.
- Bubbles: an empty stage is refilled immediately; bubbles collapse under stall, so up to NUM_PIPELINE_STAGES+3 transactions are held.
- Ordering: results emerge strictly in input order; no drops, no duplicates.
- Stability: out_data, out_op and out_valid are stable while out_valid && !out_ready.
- Counter: out_count increments by 1 on each output transfer and wraps from 2^CNT_WIDTH-1 to 0 without saturation.
- Simultaneous drain and fill of a full pipe in the same cycle: both occur, and occupancy is unchanged.
- Reset mid-operation: all in-flight transactions are discarded and out_valid drops asynchronously. The first post-reset result belongs to the first post-reset input.
- X on in_a/in_b while in_valid=0 must not propagate to out_data.

Test Plan:
- Reset, then a=3, b=5, op=XOR, fold=1, out_ready=1 -> after NUM_PIPELINE_STAGES+3 cycles: out_data=0x0010 (9^25), out_op=2, out_count=1.
- a=0x0100, b=0x00FF, fold=1, four back-to-back inputs with op 0,1,2,3 -> results 0x0001, 0xFE01, 0xFE00, 0x01FF in order on consecutive cycles.
- fold=0, a=0xF0F0, b=0xFF00: AND -> 0xF000, XNOR -> 0xF00F.
- Backpressure:
  - Hold out_ready=0 while streaming 10 inputs -> in_ready drops after NUM_PIPELINE_STAGES+3 accepts, and out_data stays stable.
  - Then release out_ready -> all accepted inputs delivered in order with no loss.
  - Random in_valid/out_ready for 1000 transactions -> matches the reference model.
- Assert rst_n low with 3 transactions in flight -> out_valid=0 and out_count=0 immediately. After release, a single input yields exactly one result.
- CNT_WIDTH=4 build, 17 transfers -> out_count reads 15 after the 15th transfer, 0 after the 16th, 1 after the 17th.
